// File: rtl/access_control_unit.sv
// Password check stage: edge-detected submit, attempt limit with timed lockout, status outputs.
// Optional password change is enabled by defining ACU_PASSWORD_CHANGE_EN.
module access_control_unit #(
    parameter logic [15:0] DEFAULT_PASSWORD = 16'h1234,
    parameter int unsigned MAX_ATTEMPTS     = 3,
    parameter int unsigned LOCKOUT_CYCLES   = 50_000_000,
    parameter int unsigned CNT_W            = 26
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_userinput,
    input  logic        i_load,
    input  logic        i_logout,
    input  logic        i_pw_change,
    output logic        o_access_granted,
    output logic        o_access_denied,
    output logic        o_locked,
    output logic [3:0]  o_attempts_left,
    output logic        o_pw_changed
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_GRANTED = 3'd2,
        S_DENIED  = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    localparam logic [3:0]       MAX_A     = 4'(MAX_ATTEMPTS);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

    // Failure count never exceeds the attempt limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        if (cnt >= MAX_A) begin
            return MAX_A;
        end else begin
            return cnt + 4'd1;
        end
    endfunction

    state_t           r_state;
    logic             r_load_q;
    logic [15:0]      r_cand;
    logic [3:0]       r_fail_cnt;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_access_granted;
    logic             r_access_denied;
    logic             r_locked;
    logic             w_submit;
    logic [15:0]      w_stored_pw;

    assign w_submit = i_load & ~r_load_q;

`ifdef ACU_PASSWORD_CHANGE_EN
    logic [15:0] r_stored_pw;
    logic        r_pw_change_q;
    logic        r_pw_changed;
    logic        w_pw_write;

    // Logout on the same edge suppresses the write.
    assign w_pw_write = (r_state == S_GRANTED) & i_pw_change & ~r_pw_change_q & ~i_logout;

    // Stored password register and its change acknowledge pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stored_pw   <= DEFAULT_PASSWORD;
            r_pw_change_q <= 1'b0;
            r_pw_changed  <= 1'b0;
        end else begin
            r_pw_change_q <= i_pw_change;
            r_pw_changed  <= w_pw_write;
            if (w_pw_write) begin
                r_stored_pw <= i_userinput;
            end
        end
    end

    assign w_stored_pw  = r_stored_pw;
    assign o_pw_changed = r_pw_changed;
`else
    logic w_unused_pw_change;

    assign w_unused_pw_change = i_pw_change;
    assign w_stored_pw        = DEFAULT_PASSWORD;
    assign o_pw_changed       = 1'b0;
`endif

    // Main access FSM with registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_load_q         <= 1'b0;
            r_cand           <= 16'h0000;
            r_fail_cnt       <= 4'd0;
            r_lock_cnt       <= {CNT_W{1'b0}};
            r_access_granted <= 1'b0;
            r_access_denied  <= 1'b0;
            r_locked         <= 1'b0;
        end else begin
            r_load_q        <= i_load;
            r_access_denied <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_submit) begin
                        r_cand  <= i_userinput;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_cand == w_stored_pw) begin
                        r_fail_cnt       <= 4'd0;
                        r_access_granted <= 1'b1;
                        r_state          <= S_GRANTED;
                    end else begin
                        r_fail_cnt      <= sat_inc(r_fail_cnt);
                        r_access_denied <= 1'b1;
                        r_state         <= S_DENIED;
                    end
                end
                S_DENIED: begin
                    if (r_fail_cnt == MAX_A) begin
                        r_lock_cnt <= LOCK_LOAD;
                        r_locked   <= 1'b1;
                        r_state    <= S_LOCKED;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOCKED: begin
                    if (r_lock_cnt == {CNT_W{1'b0}}) begin
                        r_fail_cnt <= 4'd0;
                        r_locked   <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - CNT_W'(1);
                    end
                end
                S_GRANTED: begin
                    // Logout wins over any simultaneous submit; that submit is dropped.
                    if (i_logout) begin
                        r_access_granted <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: begin
                    r_access_granted <= 1'b0;
                    r_locked         <= 1'b0;
                    r_state          <= S_IDLE;
                end
            endcase
        end
    end

    assign o_access_granted = r_access_granted;
    assign o_access_denied  = r_access_denied;
    assign o_locked         = r_locked;
    assign o_attempts_left  = MAX_A - r_fail_cnt;

endmodule

// File: doc/access_control_unit.md
Name: access_control_unit

Overview:
- Password-check stage directly downstream of the top-level process controller.
- Consumes the controller's 16-bit userinput word and load strobe. Compares the word against a stored password and returns the access_granted feedback level the controller waits on before entering GAME.
- Enforces an attempt limit with a timed lockout.
- Drives status bits for the LCD/LED logic.

Parameters:
- DEFAULT_PASSWORD, 16'h1234, password value loaded on reset.
- MAX_ATTEMPTS, 3, consecutive failed attempts that trigger lockout (1..15).
- LOCKOUT_CYCLES, 50_000_000, lockout duration in clk cycles (≥2).
- CNT_W, 26, width of lockout counter; must hold LOCKOUT_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- userinput  in  16  candidate password from controller
- load  in  1  submit strobe; raw level from the controller, may stay high many cycles
- logout  in  1  clears granted state; level, sampled each cycle
- access_granted  out  1  level; feedback to controller
- access_denied  out  1  one-cycle pulse per failed attempt
- locked  out  1  high during lockout
- attempts_left  out  4  MAX_ATTEMPTS minus consecutive failures
- pw_change  in  1  change-password strobe; used only with feature
- pw_changed  out  1  one-cycle pulse on successful change; 0 without feature

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, stored_pw=DEFAULT_PASSWORD, fail_cnt=0, lock_cnt=0, load_q=0, pw_change_q=0.
- Reset output values: access_granted=0, access_denied=0, locked=0, pw_changed=0, attempts_left=MAX_ATTEMPTS.
- Reset applies mid-operation from any state, including LOCKED and GRANTED.
- Edge detect: load_q registers load each cycle; submit = load & ~load_q. A held load produces exactly one submit.
- States: IDLE, CHECK, GRANTED, DENIED, LOCKED.
- IDLE: on submit, capture cand=userinput and go to CHECK. Otherwise stay in IDLE.
- CHECK (1 cycle): if cand==stored_pw, set fail_cnt=0 and go to GRANTED. Otherwise set fail_cnt=fail_cnt+1 and go to DENIED.
- DENIED (1 cycle): access_denied=1. If fail_cnt==MAX_ATTEMPTS, go to LOCKED and load lock_cnt=LOCKOUT_CYCLES-1. Otherwise go to IDLE.
- LOCKED: locked=1 and lock_cnt decrements each cycle. When lock_cnt==0, set fail_cnt=0 and go to IDLE.
- GRANTED: access_granted=1, held until logout=1. On logout, go to IDLE the next cycle; access_granted=0 from that edge. Submits are ignored while in GRANTED.
- Latency: from the load rising edge (the cycle with load=1, load_q=0), state enters CHECK at the next edge. access_granted or access_denied then asserts one edge later, i.e. visible 2 cycles after the cycle in which load first rises.
- Submits in CHECK, DENIED or LOCKED are discarded, not queued.
- attempts_left = MAX_ATTEMPTS - fail_cnt (registered/combinational from fail_cnt). It reads 0 during LOCKED.
- fail_cnt saturates at MAX_ATTEMPTS.
- Simultaneous logout and submit in GRANTED: logout wins. The submit is lost; a new load edge is required.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs.

Optional Feature:
- Macro: ACU_PASSWORD_CHANGE_EN.
- Defined: in GRANTED, a rising edge of pw_change (pw_change & ~pw_change_q) writes stored_pw=userinput. pw_changed pulses 1 on the following cycle and state remains GRANTED. The write is ignored if the same edge as logout (logout wins). The new password is retained until rst.
- Undefined: pw_change is ignored, pw_changed is tied to 0, and stored_pw is constant DEFAULT_PASSWORD after reset.

Test Plan:
- Reset, then load 0→1 with userinput=16'h1234 held 5 cycles:
  - access_granted=1 exactly 2 cycles after the rising edge, with a single grant.
  - attempts_left=3.
  - access_denied never pulses.
- userinput=16'h0000, two separate load pulses:
  - Two one-cycle access_denied pulses.
  - attempts_left goes 3→2→1.
  - locked=0.
- Third wrong load (LOCKOUT_CYCLES=10 in bench):
  - Third denied pulse, then locked=1 for 10 cycles.
  - A correct-password load during lockout is ignored.
  - Afterwards locked=0, attempts_left=3, and a correct load grants.
- From GRANTED: assert logout and load in the same cycle.
  - access_granted drops next cycle, state is IDLE, no CHECK occurs.
  - A fresh load edge is required to re-grant.
- Assert rst for 1 cycle during LOCKED (cycle 4 of 10):
  - Next cycle locked=0, attempts_left=3, access_granted=0.
  - 16'h1234 grants.
- With ACU_PASSWORD_CHANGE_EN, in GRANTED: set userinput=16'hBEEF and pulse pw_change.
  - pw_changed pulses once.
  - Logout, then 16'h1234 is denied and 16'hBEEF is granted.
  - Without the macro, pw_changed stays 0 and 16'h1234 still grants.
